// File: rtl/tabuleiro_ataque.sv
`default_nettype none
// ============================================================================
// Module      : tabuleiro_ataque
// Description : Battleship board stage. It passes the chosen ship map through
//               during preparation. In attack it takes shots, keeps score and
//               drives the five column maps of matriz_leds.
//               Optional macro TABULEIRO_CURSOR_EN adds a blinking aim cursor.
// Revision    : 1.0 - initial release
// ============================================================================
module tabuleiro_ataque #(
  parameter int MAX_TIROS = 15,
  parameter int BLINK_W   = 6
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       preparacao,
  input  logic       ataque,
  input  logic [6:0] mapa_in0,
  input  logic [6:0] mapa_in1,
  input  logic [6:0] mapa_in2,
  input  logic [6:0] mapa_in3,
  input  logic [6:0] mapa_in4,
  input  logic [2:0] linha,
  input  logic [2:0] coluna,
  input  logic       confirma,
  output logic [6:0] mapa0,
  output logic [6:0] mapa1,
  output logic [6:0] mapa2,
  output logic [6:0] mapa3,
  output logic [6:0] mapa4,
  output logic [3:0] tiros,
  output logic [3:0] acertos,
  output logic       invalido,
  output logic       fim_jogo,
  output logic       vitoria
);

  localparam logic [2:0] c_desl  = 3'd0;
  localparam logic [2:0] c_prep  = 3'd1;
  localparam logic [2:0] c_carga = 3'd2;
  localparam logic [2:0] c_jogo  = 3'd3;
  localparam logic [2:0] c_fim   = 3'd4;
  localparam logic [3:0] c_max_tiros = 4'(MAX_TIROS);

  logic [2:0]         r_state, w_next;
  logic               r_conf_s1, r_conf_s2, r_conf_d, w_disparo;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               w_blink;
  logic [4:0][6:0]    w_in, w_disp;
  logic [4:0][6:0]    r_navios, r_acerto, r_erro;
  logic [5:0]         r_total, w_pop;
  logic [3:0]         r_tiros, r_acertos;
  logic               r_pend, r_invalido;
  logic [2:0]         r_lin, r_col;
  logic               w_in_range, w_valid, w_fim_cond;

  assign w_in      = {mapa_in4, mapa_in3, mapa_in2, mapa_in1, mapa_in0};
  assign w_disparo = r_conf_s2 & ~r_conf_d;
  assign w_blink   = r_blink_cnt[BLINK_W-1];

  // Synchronizer plus edge-detect flop: a held button yields a single shot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_conf_s1   <= 1'b0;
      r_conf_s2   <= 1'b0;
      r_conf_d    <= 1'b0;
      r_blink_cnt <= '0;
    end else begin
      r_conf_s1   <= confirma;
      r_conf_s2   <= r_conf_s1;
      r_conf_d    <= r_conf_s2;
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  always_comb begin
    w_pop = '0;
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 7; r++)
        w_pop = w_pop + {5'd0, w_in[c][r]};
  end

  assign w_in_range = (r_lin <= 3'd6) && (r_col <= 3'd4);
  assign w_valid    = w_in_range && !(r_acerto[r_col][r_lin] | r_erro[r_col][r_lin]);
  assign w_fim_cond = ({2'b00, r_acertos} == r_total) || (r_tiros == c_max_tiros);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= c_desl;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    if (preparacao) begin
      w_next = c_prep;
    end else if (!ataque) begin
      w_next = c_desl;
    end else begin
      case (r_state)
        c_prep:  w_next = c_carga;
        c_carga: w_next = (w_pop == 6'd0) ? c_fim : c_jogo;
        c_jogo:  w_next = w_fim_cond ? c_fim : c_jogo;
        default: w_next = r_state;
      endcase
    end
  end

  // Game datapath; leaving the game clears everything on the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_navios   <= '0;
      r_acerto   <= '0;
      r_erro     <= '0;
      r_total    <= '0;
      r_tiros    <= '0;
      r_acertos  <= '0;
      r_pend     <= 1'b0;
      r_lin      <= '0;
      r_col      <= '0;
      r_invalido <= 1'b0;
    end else begin
      r_invalido <= 1'b0;
      r_pend     <= w_disparo && (r_state == c_jogo);
      if (w_disparo) begin
        r_lin <= linha;
        r_col <= coluna;
      end
      if (w_next == c_desl || w_next == c_prep) begin
        r_navios  <= '0;
        r_acerto  <= '0;
        r_erro    <= '0;
        r_total   <= '0;
        r_tiros   <= '0;
        r_acertos <= '0;
        r_pend    <= 1'b0;
      end else if (r_state == c_carga) begin
        r_navios  <= w_in;
        r_acerto  <= '0;
        r_erro    <= '0;
        r_total   <= w_pop;
        r_tiros   <= '0;
        r_acertos <= '0;
      end else if (r_state == c_jogo && r_pend) begin
        if (!w_valid) begin
          r_invalido <= 1'b1;
        end else begin
          r_tiros <= (r_tiros == 4'hF) ? r_tiros : r_tiros + 4'd1;
          if (r_navios[r_col][r_lin]) begin
            r_acerto[r_col][r_lin] <= 1'b1;
            r_acertos <= (r_acertos == 4'hF) ? r_acertos : r_acertos + 4'd1;
          end else begin
            r_erro[r_col][r_lin] <= 1'b1;
          end
        end
      end
    end
  end

  // Output logic
  always_comb begin
    w_disp = '0;
    case (r_state)
      c_prep: w_disp = w_in;
      c_jogo, c_fim: begin
        w_disp = r_acerto | (r_erro & {35{w_blink}});
`ifdef TABULEIRO_CURSOR_EN
        if (r_state == c_jogo && linha <= 3'd6 && coluna <= 3'd4)
          w_disp[coluna][linha] = w_disp[coluna][linha] ^ ~w_blink;
`endif
      end
      default: w_disp = '0;
    endcase
  end

  assign mapa0    = w_disp[0];
  assign mapa1    = w_disp[1];
  assign mapa2    = w_disp[2];
  assign mapa3    = w_disp[3];
  assign mapa4    = w_disp[4];
  assign tiros    = r_tiros;
  assign acertos  = r_acertos;
  assign invalido = r_invalido;
  assign fim_jogo = (r_state == c_fim);
  assign vitoria  = (r_state == c_fim) && ({2'b00, r_acertos} == r_total);

endmodule
`default_nettype wire

// File: tb/tb_tabuleiro_ataque.sv
`default_nettype none
// ============================================================================
// Module      : tb_tabuleiro_ataque
// Description : Directed self-checking bench for tabuleiro_ataque.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tabuleiro_ataque;

  logic       clk, rst_n;
  logic       preparacao, ataque, confirma;
  logic [6:0] mapa_in0, mapa_in1, mapa_in2, mapa_in3, mapa_in4;
  logic [2:0] linha, coluna;
  logic [6:0] mapa0, mapa1, mapa2, mapa3, mapa4;
  logic [3:0] tiros, acertos;
  logic       invalido, fim_jogo, vitoria;

  int checks = 0;
  int errors = 0;
  logic inv_k4, fim_k4, fim_k5;
  logic [5:0] cyc;
  logic [6:0] exp_col;

  tabuleiro_ataque #(.MAX_TIROS(15), .BLINK_W(6)) dut (
    .clock(clk), .reset_n(rst_n), .preparacao(preparacao), .ataque(ataque),
    .mapa_in0(mapa_in0), .mapa_in1(mapa_in1), .mapa_in2(mapa_in2),
    .mapa_in3(mapa_in3), .mapa_in4(mapa_in4),
    .linha(linha), .coluna(coluna), .confirma(confirma),
    .mapa0(mapa0), .mapa1(mapa1), .mapa2(mapa2), .mapa3(mapa3), .mapa4(mapa4),
    .tiros(tiros), .acertos(acertos), .invalido(invalido),
    .fim_jogo(fim_jogo), .vitoria(vitoria)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running blink reference, reset together with the DUT
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + 6'd1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fire(input logic [2:0] l, input logic [2:0] c);
    linha = l; coluna = c; confirma = 1'b1;
    repeat (4) tick();
    inv_k4 = invalido; fim_k4 = fim_jogo;
    confirma = 1'b0;
    tick();
    fim_k5 = fim_jogo;
    repeat (2) tick();
  endtask

  task automatic start_game();
    preparacao = 1'b1; ataque = 1'b0;
    tick();
    preparacao = 1'b0; ataque = 1'b1;
    tick();
    tick();
  endtask

  task automatic set_map(input logic [6:0] m0, input logic [6:0] m4);
    mapa_in0 = m0; mapa_in1 = '0; mapa_in2 = '0; mapa_in3 = '0; mapa_in4 = m4;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; preparacao = 0; ataque = 0; confirma = 0; linha = 0; coluna = 0;
    set_map(7'b0000111, 7'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({mapa0, mapa1, mapa2, mapa3, mapa4, tiros, acertos, invalido, fim_jogo, vitoria} !== '0) begin
      $display("FAIL reset_outputs: got %h expected 0", {mapa0, mapa1, mapa2, mapa3, mapa4, tiros, acertos, invalido, fim_jogo, vitoria});
      errors++;
    end
  endtask

  task automatic test_prep();
    preparacao = 1'b1;
    tick();
    checks++;
    if (mapa0 !== 7'b0000111) begin
      $display("FAIL prep_pass: got %b expected %b", mapa0, 7'b0000111); errors++;
    end
    mapa_in0 = 7'b0101010; #1;
    checks++;
    if (mapa0 !== 7'b0101010) begin
      $display("FAIL prep_comb: got %b expected %b", mapa0, 7'b0101010); errors++;
    end
    mapa_in0 = 7'b0000111;
    // ataque also high: preparation must still win
    ataque = 1'b1;
    tick();
    checks++;
    if (mapa0 !== 7'b0000111 || fim_jogo !== 1'b0) begin
      $display("FAIL prep_priority: got mapa0=%b fim=%b expected 0000111/0", mapa0, fim_jogo); errors++;
    end
  endtask

  task automatic test_hits();
    start_game();
    checks++;
    if (tiros !== 4'd0 || fim_jogo !== 1'b0 || mapa0 !== 7'd0) begin
      $display("FAIL game_start: got tiros=%0d fim=%b mapa0=%b expected 0/0/0", tiros, fim_jogo, mapa0); errors++;
    end
    fire(3'd0, 3'd0);
    checks++;
    if (acertos !== 4'd1 || tiros !== 4'd1 || mapa0 !== 7'b0000001) begin
      $display("FAIL hit1: got ac=%0d ti=%0d mapa0=%b expected 1/1/0000001", acertos, tiros, mapa0); errors++;
    end
    fire(3'd1, 3'd0);
    fire(3'd2, 3'd0);
    checks++;
    if (fim_k4 !== 1'b0 || fim_k5 !== 1'b1) begin
      $display("FAIL fim_latency: got k4=%b k5=%b expected 0/1", fim_k4, fim_k5); errors++;
    end
    checks++;
    if (acertos !== 4'd3 || tiros !== 4'd3 || vitoria !== 1'b1 || mapa0 !== 7'b0000111) begin
      $display("FAIL win: got ac=%0d ti=%0d vit=%b mapa0=%b expected 3/3/1/0000111", acertos, tiros, vitoria, mapa0); errors++;
    end
    repeat (40) tick();
    fire(3'd3, 3'd0);
    checks++;
    if (mapa0 !== 7'b0000111 || tiros !== 4'd3 || fim_jogo !== 1'b1 || inv_k4 !== 1'b0) begin
      $display("FAIL fim_frozen: got mapa0=%b ti=%0d fim=%b inv=%b expected 0000111/3/1/0", mapa0, tiros, fim_jogo, inv_k4); errors++;
    end
  endtask

  task automatic test_empty_map();
    set_map(7'd0, 7'd0);
    start_game();
    checks++;
    if (fim_jogo !== 1'b1 || vitoria !== 1'b1 || tiros !== 4'd0) begin
      $display("FAIL empty_map: got fim=%b vit=%b ti=%0d expected 1/1/0", fim_jogo, vitoria, tiros); errors++;
    end
  endtask

  task automatic test_invalid();
    set_map(7'b0000111, 7'd0);
    start_game();
    fire(3'd0, 3'd0);
    fire(3'd0, 3'd0);
    checks++;
    if (inv_k4 !== 1'b1 || tiros !== 4'd1 || acertos !== 4'd1) begin
      $display("FAIL repeat_cell: got inv=%b ti=%0d ac=%0d expected 1/1/1", inv_k4, tiros, acertos); errors++;
    end
    checks++;
    if (invalido !== 1'b0) begin
      $display("FAIL inv_pulse_width: got %b expected 0", invalido); errors++;
    end
    fire(3'd7, 3'd0);
    checks++;
    if (inv_k4 !== 1'b1 || tiros !== 4'd1) begin
      $display("FAIL linha7: got inv=%b ti=%0d expected 1/1", inv_k4, tiros); errors++;
    end
    fire(3'd0, 3'd5);
    checks++;
    if (inv_k4 !== 1'b1 || tiros !== 4'd1) begin
      $display("FAIL coluna5: got inv=%b ti=%0d expected 1/1", inv_k4, tiros); errors++;
    end
    fire(3'd3, 3'd1);
    exp_col = cyc[5] ? 7'b0001000 : 7'b0000000;
    checks++;
    if (inv_k4 !== 1'b0 || tiros !== 4'd2 || acertos !== 4'd1 || mapa1 !== exp_col) begin
      $display("FAIL miss: got inv=%b ti=%0d ac=%0d mapa1=%b expected 0/2/1/%b", inv_k4, tiros, acertos, mapa1, exp_col); errors++;
    end
  endtask

  task automatic test_max_shots();
    set_map(7'd0, 7'b1000000);
    start_game();
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 5; r++)
        fire(3'(r), 3'(c));
    checks++;
    if (tiros !== 4'd15 || acertos !== 4'd0 || fim_jogo !== 1'b1 || vitoria !== 1'b0) begin
      $display("FAIL max_shots: got ti=%0d ac=%0d fim=%b vit=%b expected 15/0/1/0", tiros, acertos, fim_jogo, vitoria); errors++;
    end
    for (int p = 0; p < 2; p++) begin
      exp_col = cyc[5] ? 7'b0011111 : 7'b0000000;
      checks++;
      if (mapa0 !== exp_col || mapa1 !== exp_col || mapa2 !== exp_col || mapa3 !== 7'd0 || mapa4 !== 7'd0) begin
        $display("FAIL miss_blink%0d: got %b %b %b %b %b expected %b x3, 0, 0", p, mapa0, mapa1, mapa2, mapa3, mapa4, exp_col); errors++;
      end
      repeat (32) tick();
    end
    fire(3'd6, 3'd4);
    checks++;
    if (tiros !== 4'd15 || acertos !== 4'd0 || inv_k4 !== 1'b0 || mapa4 !== 7'd0) begin
      $display("FAIL shot16: got ti=%0d ac=%0d inv=%b mapa4=%b expected 15/0/0/0", tiros, acertos, inv_k4, mapa4); errors++;
    end
  endtask

  task automatic test_hold_and_off();
    set_map(7'b0000111, 7'd0);
    start_game();
    linha = 3'd3; coluna = 3'd0; confirma = 1'b1;
    repeat (1000) tick();
    confirma = 1'b0;
    repeat (3) tick();
    checks++;
    if (tiros !== 4'd1 || acertos !== 4'd0) begin
      $display("FAIL held_button: got ti=%0d ac=%0d expected 1/0", tiros, acertos); errors++;
    end
    preparacao = 1'b0; ataque = 1'b0;
    tick();
    checks++;
    if (tiros !== 4'd0 || mapa0 !== 7'd0 || fim_jogo !== 1'b0) begin
      $display("FAIL off_desl: got ti=%0d mapa0=%b fim=%b expected 0/0/0", tiros, mapa0, fim_jogo); errors++;
    end
  endtask

  task automatic test_async_reset();
    start_game();
    fire(3'd0, 3'd0);
    fire(3'd5, 3'd2);
    checks++;
    if (acertos !== 4'd1 || tiros !== 4'd2) begin
      $display("FAIL pre_reset: got ac=%0d ti=%0d expected 1/2", acertos, tiros); errors++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mapa0, mapa1, mapa2, tiros, acertos, fim_jogo} !== '0) begin
      $display("FAIL async_reset: got %h expected 0", {mapa0, mapa1, mapa2, tiros, acertos, fim_jogo}); errors++;
    end
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    checks++;
    if (mapa0 !== 7'd0 || tiros !== 4'd0 || fim_jogo !== 1'b0) begin
      $display("FAIL after_reset_desl: got mapa0=%b ti=%0d fim=%b expected 0/0/0", mapa0, tiros, fim_jogo); errors++;
    end
  endtask

  initial begin
    test_reset();
    test_prep();
    test_hits();
    test_empty_map();
    test_invalid();
    test_max_shots();
    test_hold_and_off();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
